lc3_ctrl_fsm: RTL and testbench
===============================

Name: lc3_ctrl_fsm

Overview:
- LC-3 microsequencer. It walks fetch/decode/execute states and drives every load enable, gate and mux select on the datapath.
- It produces the LD.BEN strobe consumed by the branch comparator and the LD.CC strobe consumed by the condition-code logic.
- It consumes the registered BEN back from the comparator to resolve BR.
- It sits directly downstream of the comparator and closes the BEN loop.

Parameters:
- R_TIMEOUT, 0, max cycles to wait for memory ready R in a memory state; 0 = wait forever.
- TO_W, 8, width of the timeout counter; must satisfy R_TIMEOUT < 2**TO_W.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; one clock, asynchronous, active-high.
- IR  in  5  IR[15:11]: opcode in [4:1], IR[11] in [0] for JSR/JSRR select.
- BEN  in  1  registered branch-enable from the comparator.
- R  in  1  memory ready, level-sensitive.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  out  1 each  register load strobes.
- GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX  out  1 each  bus drivers; at most one high per cycle.
- PCMUX  out  2  0 = PC+1, 1 = BUS, 2 = ADDER.
- ADDR1MUX  out  1  0 = PC, 1 = BaseR.
- ADDR2MUX  out  2  0 = zero, 1 = off6, 2 = off9, 3 = off11.
- DRMUX  out  1  0 = IR[11:9], 1 = R7.
- SR1MUX  out  1  0 = IR[11:9], 1 = IR[8:6].
- MARMUX  out  1  0 = ZEXT IR[7:0], 1 = ADDER.
- ALUK  out  2  0 = ADD, 1 = AND, 2 = NOT, 3 = PASSA.
- MIO_EN  out  1  memory access enable.
- R_W  out  1  1 = write.
- STATE  out  6  current state number (LC-3 numbering), for debug.
- HALTED  out  1  sticky unsupported-opcode halt.
- TIMEOUT  out  1  sticky memory-timeout flag.

Behaviour:
- States (LC-3 numbers):
  - S18 fetch: MAR<-PC, PC<-PC+1.
  - S33 read: MDR<-M, wait R.
  - S35: IR<-MDR.
  - S32 decode: LD_BEN=1.
  - S1 ADD, S5 AND, S9 NOT: GATE_ALU, LD_REG, LD_CC, SR1MUX=1.
  - S0 BR, S22: PC<-PC+off9.
  - S12 JMP: PC<-BaseR, ADDR2MUX=0, PCMUX=2.
  - S14 LEA: GATE_MARMUX, MARMUX=1, LD_REG, LD_CC.
  - S2/S25/S27 LD.
  - S3/S23/S16 ST: S23 drives GATE_ALU with ALUK=PASSA, SR1MUX=0 into MDR; S16 has MIO_EN=1, R_W=1, wait R.
  - S63 HALT.
- Transitions:
  - 18->33; 33->33 while !R, ->35 on R; 35->32.
  - 32 dispatches on opcode: 0001->1, 0101->5, 1001->9, 0000->0, 1100->12, 1110->14, 0010->2, 0011->3, any other opcode->63.
  - 0->22 if BEN else ->18; 22->18.
  - 2->25; 25 waits R ->27; 3->23->16; 16 waits R ->18.
  - 1, 5, 9, 12, 14, 27 ->18.
- BEN timing: LD_BEN pulses in S32, so the comparator registers BEN at the S32->S0 edge. S0 samples BEN combinationally. No extra cycle is allowed.
- All outputs are Moore: decoded from state only. Unlisted strobes are 0 and unlisted mux selects are 0.
- RST is asynchronous: state=18, HALTED=0, TIMEOUT=0, timeout counter=0. Outputs reflect S18 immediately after reset.
- Reset mid-access drops MIO_EN combinationally.
- HALT (S63) is absorbing until RST. All strobes and MIO_EN are 0; HALTED=1.
- Timeout (R_TIMEOUT>0):
  - Counter clears on entry to S33/S25/S16 and increments each waiting cycle.
  - When the counter reaches R_TIMEOUT with R still low: set TIMEOUT, go to S63.
  - R high on the same cycle as the limit wins: normal transition.

Optional Feature:
- LC3_JSR_EN defined:
  - Opcode 0100 is legal: 32->4 (R7<-PC: DRMUX=1, GATE_PC, LD_REG).
  - Then IR[11]=1 ->21 (PC<-PC+off11, ADDR1MUX=0, ADDR2MUX=3, PCMUX=2).
  - Or IR[11]=0 ->20 (PC<-BaseR, ADDR1MUX=1, ADDR2MUX=0, PCMUX=2).
  - 20 and 21 ->18.
  - LD_CC stays 0 in S4.
- LC3_JSR_EN undefined: opcode 0100 ->63 and states 4/20/21 do not exist.

Decomposition:
- Package lc3_ctrl_pkg:
  - state enum with LC-3 numbers.
  - opcode constants.
  - PCMUX/ADDR2MUX/ALUK encodings.
  - packed control-word struct.
- One sub-module, lc3_ctrl_rom: pure combinational state -> control-word decode. The FSM holds only next-state logic and the timeout counter.

Test Plan:
- Reset, then fetch ADD (0001) with R high on the 2nd S33 cycle -> state sequence 18,33,33,35,32,1,18; LD_CC=1 and GATE_ALU=1 only in S1.
- BR with BEN=1 at S0 -> 0,22,18; PCMUX=2 and LD_PC=1 in S22. Same with BEN=0 -> 0,18 and no LD_PC.
- ST with R held low 3 cycles in S16 -> MIO_EN=1, R_W=1 for 4 cycles, then 18.
- Opcode 1111 (TRAP) -> S63, HALTED=1, all strobes 0 for 20 cycles; RST pulse -> state 18, HALTED=0.
- R_TIMEOUT=4, R never rises in S33 -> TIMEOUT=1 and S63 after exactly 4 wait cycles. Variant: R rises on the 4th cycle -> proceeds to S35.
- Assert RST during S25 -> MIO_EN=0 immediately, state 18 next cycle.
- With LC3_JSR_EN, JSR with IR[11]=1 -> 4,21,18; DRMUX=1 and LD_REG=1 in S4.

Source files
------------

// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the LC-3 microsequencer: state numbering, opcodes, mux encodings, control word.
// LC3_JSR_EN adds the JSR/JSRR states 4, 20 and 21.
package lc3_ctrl_pkg;

  localparam int unsigned STATE_W = 6;
  localparam int unsigned OP_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    S0  = 6'd0,
    S1  = 6'd1,
    S2  = 6'd2,
    S3  = 6'd3,
`ifdef LC3_JSR_EN
    S4  = 6'd4,
    S20 = 6'd20,
    S21 = 6'd21,
`endif
    S5  = 6'd5,
    S9  = 6'd9,
    S12 = 6'd12,
    S14 = 6'd14,
    S16 = 6'd16,
    S18 = 6'd18,
    S22 = 6'd22,
    S23 = 6'd23,
    S25 = 6'd25,
    S27 = 6'd27,
    S32 = 6'd32,
    S33 = 6'd33,
    S35 = 6'd35,
    S63 = 6'd63
  } state_e;

  localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OP_W-1:0] OP_JSR = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OP_W-1:0] OP_LEA = 4'b1110;

  localparam logic [1:0] PCMUX_INC   = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_ADDER = 2'd2;

  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2_OFF11 = 2'd3;

  localparam logic [1:0] ALUK_ADD   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_NOT   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       drmux;
    logic       sr1mux;
    logic       marmux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       r_w;
  } ctrl_word_t;

endpackage

// File: rtl/lc3_ctrl_rom.sv
// Control store: pure state -> control-word decode. LC3_JSR_EN adds words for states 4/20/21.
module lc3_ctrl_rom
  import lc3_ctrl_pkg::*;
(
  input  state_e     state,
  output ctrl_word_t cw_c
);

  always_comb begin
    cw_c = '0;
    case (state)
      S18: begin cw_c.ld_mar = 1'b1; cw_c.gate_pc = 1'b1; cw_c.ld_pc = 1'b1; cw_c.pcmux = PCMUX_INC; end
      S33, S25: begin cw_c.ld_mdr = 1'b1; cw_c.mio_en = 1'b1; end
      S35: begin cw_c.gate_mdr = 1'b1; cw_c.ld_ir = 1'b1; end
      S32: cw_c.ld_ben = 1'b1;
      S1, S5, S9: begin
        cw_c.gate_alu = 1'b1;
        cw_c.ld_reg   = 1'b1;
        cw_c.ld_cc    = 1'b1;
        cw_c.sr1mux   = 1'b1;
        cw_c.aluk     = (state == S1) ? ALUK_ADD : (state == S5) ? ALUK_AND : ALUK_NOT;
      end
      S22: begin cw_c.ld_pc = 1'b1; cw_c.pcmux = PCMUX_ADDER; cw_c.addr2mux = ADDR2_OFF9; end
      S12: begin
        cw_c.ld_pc    = 1'b1;
        cw_c.pcmux    = PCMUX_ADDER;
        cw_c.addr1mux = 1'b1;
        cw_c.addr2mux = ADDR2_ZERO;
      end
      S14: begin
        cw_c.gate_marmux = 1'b1;
        cw_c.marmux      = 1'b1;
        cw_c.ld_reg      = 1'b1;
        cw_c.ld_cc       = 1'b1;
        cw_c.addr2mux    = ADDR2_OFF9;
      end
      // LD/ST effective address PC+off9 through MARMUX into MAR
      S2, S3: begin
        cw_c.ld_mar      = 1'b1;
        cw_c.gate_marmux = 1'b1;
        cw_c.marmux      = 1'b1;
        cw_c.addr2mux    = ADDR2_OFF9;
      end
      S27: begin cw_c.gate_mdr = 1'b1; cw_c.ld_reg = 1'b1; cw_c.ld_cc = 1'b1; end
      S23: begin cw_c.ld_mdr = 1'b1; cw_c.gate_alu = 1'b1; cw_c.aluk = ALUK_PASSA; cw_c.sr1mux = 1'b0; end
      S16: begin cw_c.mio_en = 1'b1; cw_c.r_w = 1'b1; end
`ifdef LC3_JSR_EN
      S4: begin cw_c.drmux = 1'b1; cw_c.gate_pc = 1'b1; cw_c.ld_reg = 1'b1; end
      S21: begin
        cw_c.ld_pc    = 1'b1;
        cw_c.pcmux    = PCMUX_ADDER;
        cw_c.addr1mux = 1'b0;
        cw_c.addr2mux = ADDR2_OFF11;
      end
      S20: begin
        cw_c.ld_pc    = 1'b1;
        cw_c.pcmux    = PCMUX_ADDER;
        cw_c.addr1mux = 1'b1;
        cw_c.addr2mux = ADDR2_ZERO;
      end
`endif
      default: cw_c = '0;
    endcase
  end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 microsequencer: next-state logic, memory-ready timeout and sticky halt/timeout flags.
// Define LC3_JSR_EN to make opcode 0100 (JSR/JSRR) legal.
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned R_TIMEOUT = 0,
  parameter int unsigned TO_W      = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] IR,
  input  logic       BEN,
  input  logic       R,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_REG,
  output logic       LD_CC,
  output logic       LD_PC,
  output logic       GATE_PC,
  output logic       GATE_MDR,
  output logic       GATE_ALU,
  output logic       GATE_MARMUX,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       MARMUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       R_W,
  output logic [5:0] STATE,
  output logic       HALTED,
  output logic       TIMEOUT
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((R_TIMEOUT == 0) ? 0 : R_TIMEOUT - 1);

  state_e            state_q, state_n;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_n;
  logic              halted_q, timeout_q;
  logic              waiting_c, to_hit_c;
  ctrl_word_t        cw_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S18;
      to_cnt_q  <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      to_cnt_q <= to_cnt_n;
      if (state_n == S63) halted_q  <= 1'b1;
      if (to_hit_c)       timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state_q;
    to_cnt_n  = to_cnt_q;
    waiting_c = ((state_q == S33) || (state_q == S25) || (state_q == S16)) && !R;
    to_hit_c  = (R_TIMEOUT != 0) && waiting_c && (to_cnt_q == TO_LAST);
    case (state_q)
      S18: state_n = S33;
      S33: if (R) state_n = S35;
      S35: state_n = S32;
      S32: begin
        case (IR[4:1])
          OP_ADD:  state_n = S1;
          OP_AND:  state_n = S5;
          OP_NOT:  state_n = S9;
          OP_BR:   state_n = S0;
          OP_JMP:  state_n = S12;
          OP_LEA:  state_n = S14;
          OP_LD:   state_n = S2;
          OP_ST:   state_n = S3;
`ifdef LC3_JSR_EN
          OP_JSR:  state_n = S4;
`endif
          default: state_n = S63;
        endcase
      end
      // BEN was registered at the S32->S0 edge, so it is valid here
      S0:  state_n = BEN ? S22 : S18;
      S2:  state_n = S25;
      S25: if (R) state_n = S27;
      S3:  state_n = S23;
      S23: state_n = S16;
      S16: if (R) state_n = S18;
`ifdef LC3_JSR_EN
      S4:  state_n = IR[0] ? S21 : S20;
      S20, S21: state_n = S18;
`endif
      S1, S5, S9, S12, S14, S22, S27: state_n = S18;
      S63: state_n = S63;
      default: state_n = S63;
    endcase
    if (to_hit_c) state_n = S63;
    // counter restarts on entry to a memory state and counts cycles spent waiting
    if ((state_n != state_q) && ((state_n == S33) || (state_n == S25) || (state_n == S16)))
      to_cnt_n = '0;
    else if (waiting_c)
      to_cnt_n = to_cnt_q + TO_W'(1);
  end

  lc3_ctrl_rom u_rom (
    .state (state_q),
    .cw_c  (cw_c)
  );

  assign LD_MAR      = cw_c.ld_mar;
  assign LD_MDR      = cw_c.ld_mdr;
  assign LD_IR       = cw_c.ld_ir;
  assign LD_BEN      = cw_c.ld_ben;
  assign LD_REG      = cw_c.ld_reg;
  assign LD_CC       = cw_c.ld_cc;
  assign LD_PC       = cw_c.ld_pc;
  assign GATE_PC     = cw_c.gate_pc;
  assign GATE_MDR    = cw_c.gate_mdr;
  assign GATE_ALU    = cw_c.gate_alu;
  assign GATE_MARMUX = cw_c.gate_marmux;
  assign PCMUX       = cw_c.pcmux;
  assign ADDR1MUX    = cw_c.addr1mux;
  assign ADDR2MUX    = cw_c.addr2mux;
  assign DRMUX       = cw_c.drmux;
  assign SR1MUX      = cw_c.sr1mux;
  assign MARMUX      = cw_c.marmux;
  assign ALUK        = cw_c.aluk;
  assign MIO_EN      = cw_c.mio_en;
  assign R_W         = cw_c.r_w;
  assign STATE       = state_q;
  assign HALTED      = halted_q;
  assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Bench for lc3_ctrl_fsm (R_TIMEOUT=4): per-instruction expected state/flag trace built from the
// instruction flow rules, compared cycle by cycle. Honours LC3_JSR_EN like the design.
module tb_lc3_ctrl_fsm;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] IR  = '0;
  logic       BEN = 1'b0;
  logic       R   = 1'b0;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
  logic GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, DRMUX, SR1MUX, MARMUX, MIO_EN, R_W, HALTED, TIMEOUT;
  logic [5:0] STATE;
  logic [22:0] dut_ctl;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {int st; bit r; bit hal; bit tmo;} step_t;
  step_t q[$];
  bit m_hal = 1'b0;
  bit m_tmo = 1'b0;

  lc3_ctrl_fsm #(.R_TIMEOUT(TO), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST), .IR(IR), .BEN(BEN), .R(R),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_REG(LD_REG),
    .LD_CC(LD_CC), .LD_PC(LD_PC), .GATE_PC(GATE_PC), .GATE_MDR(GATE_MDR), .GATE_ALU(GATE_ALU),
    .GATE_MARMUX(GATE_MARMUX), .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .MARMUX(MARMUX), .ALUK(ALUK), .MIO_EN(MIO_EN), .R_W(R_W),
    .STATE(STATE), .HALTED(HALTED), .TIMEOUT(TIMEOUT)
  );

  assign dut_ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
                    GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX, PCMUX, ADDR1MUX, ADDR2MUX,
                    DRMUX, SR1MUX, MARMUX, ALUK, MIO_EN, R_W};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Datapath action of each state, written from the micro-op descriptions
  function automatic logic [22:0] exp_ctl(input int s);
    logic ld_mar = 0, ld_mdr = 0, ld_ir = 0, ld_ben = 0, ld_reg = 0, ld_cc = 0, ld_pc = 0;
    logic g_pc = 0, g_mdr = 0, g_alu = 0, g_mm = 0, a1 = 0, dr = 0, sr1 = 0, mm = 0, mio = 0, rw = 0;
    logic [1:0] pcm = 0, a2 = 0, aluk = 0;
    case (s)
      18: begin ld_mar = 1; g_pc = 1; ld_pc = 1; end
      33, 25: begin ld_mdr = 1; mio = 1; end
      35: begin g_mdr = 1; ld_ir = 1; end
      32: ld_ben = 1;
      1, 5, 9: begin
        g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1;
        aluk = (s == 1) ? 2'd0 : (s == 5) ? 2'd1 : 2'd2;
      end
      22: begin ld_pc = 1; pcm = 2; a2 = 2; end
      12: begin ld_pc = 1; pcm = 2; a1 = 1; end
      14: begin g_mm = 1; mm = 1; ld_reg = 1; ld_cc = 1; a2 = 2; end
      2, 3: begin ld_mar = 1; g_mm = 1; mm = 1; a2 = 2; end
      27: begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
      23: begin ld_mdr = 1; g_alu = 1; aluk = 3; end
      16: begin mio = 1; rw = 1; end
      4:  begin dr = 1; g_pc = 1; ld_reg = 1; end
      21: begin ld_pc = 1; pcm = 2; a2 = 3; end
      20: begin ld_pc = 1; pcm = 2; a1 = 1; end
      default: ;
    endcase
    return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc, g_pc, g_mdr, g_alu, g_mm,
            pcm, a1, a2, dr, sr1, mm, aluk, mio, rw};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input int s, input bit r);
    step_t e;
    if (s == 63) m_hal = 1'b1;
    e.st = s; e.r = r; e.hal = m_hal; e.tmo = m_tmo;
    q.push_back(e);
  endfunction

  // Memory wait: 'waits' low cycles then R; TO low cycles in a row ends in S63 with TIMEOUT
  function automatic bit push_wait(input int s, input int waits);
    if (waits >= TO) begin
      for (int i = 0; i < TO; i++) push(s, 1'b0);
      m_tmo = 1'b1;
      push(63, rb());
      return 1'b1;
    end
    for (int i = 0; i < waits; i++) push(s, 1'b0);
    push(s, 1'b1);
    return 1'b0;
  endfunction

  task automatic build(input int op, input bit ir11, input bit ben, input int wf, input int wm,
                       input int halt_extra);
    bit t;
    push(18, rb());
    t = push_wait(33, wf);
    if (!t) begin
      push(35, rb());
      push(32, rb());
      case (op)
        1, 5, 9, 12, 14: push(op, rb());
        0: begin push(0, rb()); if (ben) push(22, rb()); end
        2: begin push(2, rb()); t = push_wait(25, wm); if (!t) push(27, rb()); end
        3: begin push(3, rb()); push(23, rb()); t = push_wait(16, wm); end
`ifdef LC3_JSR_EN
        4: begin push(4, rb()); push(ir11 ? 21 : 20, rb()); end
`endif
        default: push(63, rb());
      endcase
    end
    if (m_hal) for (int i = 0; i < halt_extra; i++) push(63, rb());
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_state", 32'(STATE), 32'd18);
    chk("rst_ctl", 32'(dut_ctl), 32'(exp_ctl(18)));
    chk("rst_halted", 32'(HALTED), 32'd0);
    chk("rst_timeout", 32'(TIMEOUT), 32'd0);
    RST = 1'b0;
    m_hal = 1'b0;
    m_tmo = 1'b0;
  endtask

  // Plays the trace from just after a falling edge; rst_at >= 0 aborts with RST at that step
  task automatic run(input int rst_at);
    step_t e;
    int idx = 0;
    bit aborted = 1'b0;
    while (q.size() > 0 && !aborted) begin
      e = q.pop_front();
      R = e.r;
      #1;
      chk("state", 32'(STATE), 32'(e.st));
      chk("ctl", 32'(dut_ctl), 32'(exp_ctl(e.st)));
      chk("halted", 32'(HALTED), 32'(e.hal));
      chk("timeout", 32'(TIMEOUT), 32'(e.tmo));
      if (idx == rst_at) begin
        RST = 1'b1;
        #1;
        chk("midrst_mio_en", 32'(MIO_EN), 32'd0);
        chk("midrst_state", 32'(STATE), 32'd18);
        @(negedge CLK);
        chk("midrst_hold", 32'(STATE), 32'd18);
        RST = 1'b0;
        q.delete();
        m_hal = 1'b0;
        m_tmo = 1'b0;
        aborted = 1'b1;
      end else begin
        idx++;
        @(negedge CLK);
      end
    end
    if (m_hal) do_reset();
  endtask

  task automatic instr(input int op, input bit ir11, input bit ben, input int wf, input int wm,
                       input int halt_extra, input int rst_at);
    IR  = {4'(op), ir11};
    BEN = ben;
    build(op, ir11, ben, wf, wm, halt_extra);
    run(rst_at);
  endtask

  initial begin
    int legal [9] = '{1, 5, 9, 0, 12, 14, 2, 3, 4};
    int op, wf, wm;
    @(negedge CLK);
    do_reset();

    instr(1, 0, 0, 1, 0, 0, -1);    // ADD, R on 2nd S33 cycle
    instr(0, 0, 1, 0, 0, 0, -1);    // BR taken
    instr(0, 0, 0, 0, 0, 0, -1);    // BR not taken
    instr(3, 0, 0, 0, 3, 0, -1);    // ST, 3 low cycles in S16
    instr(15, 0, 0, 0, 0, 20, -1);  // TRAP -> halt
    instr(5, 0, 0, 4, 0, 2, -1);    // fetch timeout
    instr(9, 0, 0, 3, 0, 0, -1);    // R on the limit cycle wins
    instr(2, 0, 0, 0, 3, 0, 6);     // reset during S25
    instr(2, 0, 0, 0, 3, 0, -1);    // LD completes from reset state
`ifdef LC3_JSR_EN
    instr(4, 1, 0, 0, 0, 0, -1);
    instr(4, 0, 0, 1, 0, 0, -1);
`endif

    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 8)] : int'($urandom_range(0, 15));
      wf = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      wm = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      instr(op, rb(), rb(), wf, wm, int'($urandom_range(1, 3)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
